// File: rtl/riscv_soft_defines_pkg.sv
// Shared RV32I decode constants: immediate-format selects and base opcodes, plus
// the predecode result record and the decode-stage occupancy states.
package riscv_soft_defines;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_X = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } predecode_t;

  localparam predecode_t PREDECODE_RESET = '{imm_sel: IMM_X, rs1: 5'd0, rs2: 5'd0,
                                             rd: 5'd0, illegal: 1'b0};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/riscv_soft_decode_stage_predecode.sv
// Combinational predecode: opcode -> immediate format and legality, plus raw
// register index fields. Only the instruction fields actually decoded are ported in.
module riscv_soft_inst_predecode
  import riscv_soft_defines::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd_field,
  input  logic [4:0]  rs1_field,
  input  logic [4:0]  rs2_field,
  output predecode_t  dec
);

  always_comb begin
    dec         = PREDECODE_RESET;
    dec.rs1     = rs1_field;
    dec.rs2     = rs2_field;
    dec.rd      = rd_field;
    dec.imm_sel = IMM_X;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: dec.imm_sel = IMM_I;
      OPC_STORE:                                                dec.imm_sel = IMM_S;
      OPC_BRANCH:                                               dec.imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:                                       dec.imm_sel = IMM_U;
      OPC_JAL:                                                  dec.imm_sel = IMM_J;
      OPC_OP:                                                   dec.imm_sel = IMM_X;
      default:                                                  dec.illegal = 1'b1;
    endcase
    // Compressed-encoding space is never legal here; covered by the default too.
    if (opcode[1:0] != 2'b11) dec.illegal = 1'b1;
  end

endmodule

// File: rtl/riscv_soft_decode_stage.sv
// Decode stage: predecodes fetched instructions into a registered output slot with
// a one-entry skid behind it so that if_ready is a pure flop output.
module riscv_soft_decode_stage
  import riscv_soft_defines::*;
#(
  parameter int          XPR_LEN    = 32,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        if_inst,
  input  logic [XPR_LEN-1:0] if_pc,
  input  logic               flush,
  output logic               de_valid,
  input  logic               de_ready,
  output logic [31:0]        de_inst,
  output logic [XPR_LEN-1:0] de_pc,
  output logic [2:0]         de_imm_sel,
  output logic [4:0]         de_rs1,
  output logic [4:0]         de_rs2,
  output logic [4:0]         de_rd,
  output logic               de_illegal
);

  predecode_t         dec_p0;

  occ_state_e         state_q;
  occ_state_e         state_nxt;
  logic               vld_p1;
  logic               if_ready_q;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid;
  logic               in_xfer;
  logic               out_xfer;

  logic [31:0]        main_inst_p1;
  logic [XPR_LEN-1:0] main_pc_p1;
  predecode_t         main_dec_p1;
  logic [31:0]        skid_inst_p1;
  logic [XPR_LEN-1:0] skid_pc_p1;
  predecode_t         skid_dec_p1;

  // Stage p0: decode straight off the fetch bus
  riscv_soft_inst_predecode u_predecode (
    .opcode    (if_inst[6:0]),
    .rd_field  (if_inst[11:7]),
    .rs1_field (if_inst[19:15]),
    .rs2_field (if_inst[24:20]),
    .dec       (dec_p0)
  );

  assign in_xfer  = if_valid & if_ready_q;
  assign out_xfer = vld_p1 & de_ready;

  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            state_nxt    = OCC_ONE;
            load_main_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_nxt = OCC_TWO;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            state_nxt      = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OCC_EMPTY;
      vld_p1     <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      vld_p1     <= (state_nxt != OCC_EMPTY);
      if_ready_q <= (state_nxt != OCC_TWO);
    end
  end

  // Stage p1: output slot, visible on de_* and held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_inst_p1 <= RESET_INST;
      main_pc_p1   <= '0;
      main_dec_p1  <= PREDECODE_RESET;
    end else if (load_main_in) begin
      main_inst_p1 <= if_inst;
      main_pc_p1   <= if_pc;
      main_dec_p1  <= dec_p0;
    end else if (load_main_skid) begin
      main_inst_p1 <= skid_inst_p1;
      main_pc_p1   <= skid_pc_p1;
      main_dec_p1  <= skid_dec_p1;
    end
  end

  // Skid slot contents are only meaningful in OCC_TWO, so no reset is needed
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_inst_p1 <= if_inst;
      skid_pc_p1   <= if_pc;
      skid_dec_p1  <= dec_p0;
    end
  end

  assign if_ready   = if_ready_q;
  assign de_valid   = vld_p1;
  assign de_inst    = main_inst_p1;
  assign de_pc      = main_pc_p1;
  assign de_imm_sel = main_dec_p1.imm_sel;
  assign de_rs1     = main_dec_p1.rs1;
  assign de_rs2     = main_dec_p1.rs2;
  assign de_rd      = main_dec_p1.rd;
  assign de_illegal = main_dec_p1.illegal;

endmodule

// File: tb/tb_riscv_soft_decode_stage.sv
// Directed bench for riscv_soft_decode_stage: vector table for decode, hand
// sequences for backpressure, flush and asynchronous reset.
module tb_riscv_soft_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        flush;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_inst;
  logic [31:0] de_pc;
  logic [2:0]  de_imm_sel;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic [4:0]  de_rd;
  logic        de_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  riscv_soft_decode_stage #(.XPR_LEN(32), .RESET_INST(32'h00000013)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .flush      (flush),
    .de_valid   (de_valid),
    .de_ready   (de_ready),
    .de_inst    (de_inst),
    .de_pc      (de_pc),
    .de_imm_sel (de_imm_sel),
    .de_rs1     (de_rs1),
    .de_rs2     (de_rs2),
    .de_rd      (de_rd),
    .de_illegal (de_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h00500093, 3'd0, 5'd0, 5'd5, 5'd1, 1'b0}; // ADDI x1,x0,5
    vecs[1] = '{32'h00112223, 3'd1, 5'd2, 5'd1, 5'd4, 1'b0}; // SW
    vecs[2] = '{32'h00208463, 3'd2, 5'd1, 5'd2, 5'd8, 1'b0}; // BEQ
    vecs[3] = '{32'h123450B7, 3'd3, 5'd8, 5'd3, 5'd1, 1'b0}; // LUI
    vecs[4] = '{32'h0080006F, 3'd4, 5'd0, 5'd8, 5'd0, 1'b0}; // JAL
    vecs[5] = '{32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 1'b1}; // bad opcode
    vecs[6] = '{32'h00000010, 3'd7, 5'd0, 5'd0, 5'd0, 1'b1}; // inst[1:0]!=11
    vecs[7] = '{32'h002081B3, 3'd7, 5'd1, 5'd2, 5'd3, 1'b0}; // ADD x3,x1,x2
    vecs[8] = '{32'h00000073, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0}; // ECALL
    vecs[9] = '{32'h00000097, 3'd3, 5'd0, 5'd0, 5'd1, 1'b0}; // AUIPC x1,0

    if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0; de_ready = 1'b0;

    // Reset values
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_de_valid", de_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_de_inst", de_inst, 32'h00000013);
    chk("rst_de_pc", de_pc, 0);
    chk("rst_imm_sel", de_imm_sel, 7);
    chk("rst_rd", de_rd, 0);
    chk("rst_illegal", de_illegal, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_de_valid", de_valid, 0);

    // Streaming decode table, one instruction per cycle
    de_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if_valid = 1'b1;
      if_inst  = vecs[i].inst;
      if_pc    = 32'h100 + 32'(i) * 4;
      tick();
      chk($sformatf("v%0d_valid", i), de_valid, 1);
      chk($sformatf("v%0d_inst", i), de_inst, vecs[i].inst);
      chk($sformatf("v%0d_pc", i), de_pc, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), de_imm_sel, vecs[i].imm);
      chk($sformatf("v%0d_rs1", i), de_rs1, vecs[i].rs1);
      chk($sformatf("v%0d_rs2", i), de_rs2, vecs[i].rs2);
      chk($sformatf("v%0d_rd", i), de_rd, vecs[i].rd);
      chk($sformatf("v%0d_ill", i), de_illegal, vecs[i].ill);
      chk($sformatf("v%0d_ready", i), if_ready, 1);
    end
    if_valid = 1'b0;
    tick();
    chk("drain_valid", de_valid, 0);

    // Backpressure: A, B fill the stage, C waits
    de_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h200;
    tick();
    chk("bp_a_valid", de_valid, 1);
    chk("bp_a_inst", de_inst, 32'h00500093);
    chk("bp_a_ready", if_ready, 1);
    if_inst = 32'h00112223; if_pc = 32'h204;
    tick();
    chk("bp_two_ready", if_ready, 0);
    chk("bp_two_inst", de_inst, 32'h00500093);
    if_inst = 32'h00208463; if_pc = 32'h208;
    tick();
    chk("bp_hold_ready", if_ready, 0);
    chk("bp_hold_inst", de_inst, 32'h00500093);
    chk("bp_hold_pc", de_pc, 32'h200);
    chk("bp_hold_valid", de_valid, 1);
    de_ready = 1'b1;
    tick();
    chk("bp_b_inst", de_inst, 32'h00112223);
    chk("bp_b_pc", de_pc, 32'h204);
    chk("bp_b_imm", de_imm_sel, 1);
    chk("bp_b_ready", if_ready, 1);
    tick();
    chk("bp_c_inst", de_inst, 32'h00208463);
    chk("bp_c_imm", de_imm_sel, 2);
    chk("bp_c_valid", de_valid, 1);
    if_valid = 1'b0;
    tick();
    chk("bp_empty", de_valid, 0);

    // Flush in TWO with an incoming instruction
    de_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h123450B7; if_pc = 32'h300;
    tick();
    if_inst = 32'h0080006F; if_pc = 32'h304;
    tick();
    chk("fl2_pre_ready", if_ready, 0);
    flush = 1'b1; if_inst = 32'h0000007F; if_pc = 32'h308;
    tick();
    chk("fl2_valid", de_valid, 0);
    chk("fl2_ready", if_ready, 1);
    flush = 1'b0; if_valid = 1'b0; de_ready = 1'b1;
    tick();
    chk("fl2_after_valid", de_valid, 0);
    tick();
    chk("fl2_after2_valid", de_valid, 0);

    // Flush in ONE while if_ready=1: incoming instruction dropped
    de_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00500093; if_pc = 32'h400;
    tick();
    chk("fl1_pre_ready", if_ready, 1);
    flush = 1'b1; if_inst = 32'h002081B3; if_pc = 32'h404;
    tick();
    chk("fl1_valid", de_valid, 0);
    chk("fl1_ready", if_ready, 1);
    flush = 1'b0; if_valid = 1'b0;
    tick();
    chk("fl1_after_valid", de_valid, 0);

    // Asynchronous reset mid-stream in TWO
    if_valid = 1'b1; if_inst = 32'h00112223; if_pc = 32'h500;
    tick();
    if_inst = 32'h00208463; if_pc = 32'h504;
    tick();
    chk("ar_pre_ready", if_ready, 0);
    chk("ar_pre_valid", de_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", de_valid, 0);
    chk("ar_ready", if_ready, 1);
    chk("ar_inst", de_inst, 32'h00000013);
    chk("ar_pc", de_pc, 0);
    chk("ar_imm", de_imm_sel, 7);
    if_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_post_valid", de_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
